// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam int unsigned LU_STALL_CYC_DEF = 1;
  localparam int unsigned LU_STALL_MAX     = 4;
  localparam int unsigned LU_CTR_W         = 3;

  // Control-field widths of the pipeline buffers and MemRead position in M {Branch, MemRead, MemWrite}.
  localparam int unsigned WB_W          = 2;
  localparam int unsigned M_W           = 3;
  localparam int unsigned EX_W          = 5;
  localparam int unsigned M_MEMREAD_BIT = 1;

  // Clamp a requested load-use stall length into the supported 1..LU_STALL_MAX range.
  function automatic int unsigned lu_cycles(input int unsigned req);
    if (req < 1) begin
      return 1;
    end else if (req > LU_STALL_MAX) begin
      return LU_STALL_MAX;
    end
    return req;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall/bubble, branch flush, external
// freeze, and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned LU_STALL_CYC = LU_STALL_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             br_taken,
  input  logic             ext_stall,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned LU_CYC = lu_cycles(LU_STALL_CYC);
  localparam logic [LU_CTR_W-1:0] LU_INIT = LU_CTR_W'(LU_CYC - 1);

  state_t              state;
  state_t              state_nxt;
  logic [LU_CTR_W-1:0] lu_ctr;
  logic [LU_CTR_W-1:0] lu_ctr_nxt;
  logic                lu_hit;

  // A load into $zero never produces a value worth waiting for.
  assign lu_hit = idex_memread && (idex_rt != '0) &&
                  ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      lu_ctr <= '0;
    end else begin
      state  <= state_nxt;
      lu_ctr <= lu_ctr_nxt;
    end
  end

  // Priority: reset > branch flush > external freeze > load-use stall.
  always_comb begin
    state_nxt   = state;
    lu_ctr_nxt  = lu_ctr;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;

    if (!rst_n) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      state_nxt   = RUN;
      lu_ctr_nxt  = '0;
    end else if (ext_stall) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
    end else if ((state == STALL) || lu_hit) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      if (state == STALL) begin
        if (lu_ctr <= LU_CTR_W'(1)) begin
          state_nxt  = RUN;
          lu_ctr_nxt = '0;
        end else begin
          lu_ctr_nxt = lu_ctr - LU_CTR_W'(1);
        end
      end else if (LU_CYC > 1) begin
        state_nxt  = STALL;
        lu_ctr_nxt = LU_INIT;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (~rst_n),
    .inc   (~pc_we),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (~rst_n),
    .inc   (br_taken),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl across three parameterisations sharing one stimulus bus.
module tb_hazard_ctrl;

  // Control vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_flush}
  localparam logic [5:0] C_DEF = 6'b110100;
  localparam logic [5:0] C_BUB = 6'b000110;
  localparam logic [5:0] C_BR  = 6'b111111;
  localparam logic [5:0] C_EXT = 6'b000000;
  localparam logic [5:0] C_RST = 6'b001111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic       id_uses_rt, idex_memread, br_taken, ext_stall;

  logic [5:0]  ctl1, ctl2, ctl3;
  logic [15:0] stall1, flush1, stall3, flush3;
  logic [3:0]  stall2, flush2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .CNT_W(16), .LU_STALL_CYC(1)) u_lu1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .br_taken(br_taken), .ext_stall(ext_stall),
    .pc_we(ctl1[5]), .ifid_we(ctl1[4]), .ifid_flush(ctl1[3]), .idex_we(ctl1[2]),
    .idex_bubble(ctl1[1]), .exmem_flush(ctl1[0]), .stall_cnt(stall1), .flush_cnt(flush1)
  );

  hazard_ctrl #(.REG_W(5), .CNT_W(4), .LU_STALL_CYC(2)) u_lu2 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .br_taken(br_taken), .ext_stall(ext_stall),
    .pc_we(ctl2[5]), .ifid_we(ctl2[4]), .ifid_flush(ctl2[3]), .idex_we(ctl2[2]),
    .idex_bubble(ctl2[1]), .exmem_flush(ctl2[0]), .stall_cnt(stall2), .flush_cnt(flush2)
  );

  hazard_ctrl #(.REG_W(5), .CNT_W(16), .LU_STALL_CYC(3)) u_lu3 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .br_taken(br_taken), .ext_stall(ext_stall),
    .pc_we(ctl3[5]), .ifid_we(ctl3[4]), .ifid_flush(ctl3[3]), .idex_we(ctl3[2]),
    .idex_bubble(ctl3[1]), .exmem_flush(ctl3[0]), .stall_cnt(stall3), .flush_cnt(flush3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; idex_rt = '0;
    id_uses_rt = 1'b0; idex_memread = 1'b0; br_taken = 1'b0; ext_stall = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();

    // Reset with a live hazard and branch on the inputs
    idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8; br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rst_forced_ctl", 32'(ctl1), 32'(C_RST));
      tick();
    end
    rst_n = 1'b1;
    idle();
    #1;
    check("rst_stall_cnt", 32'(stall1), 32'd0);
    check("rst_flush_cnt", 32'(flush1), 32'd0);
    check("rst_release_ctl", 32'(ctl1), 32'(C_DEF));

    // Load-use, one bubble
    do_reset();
    idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    #1 check("lu1_bubble", 32'(ctl1), 32'(C_BUB));
    tick();
    idex_memread = 1'b0;
    #1 check("lu1_resume", 32'(ctl1), 32'(C_DEF));
    check("lu1_stall_cnt", 32'(stall1), 32'd1);
    idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
    #1 check("lu1_zero_dest", 32'(ctl1), 32'(C_DEF));
    tick();
    idex_memread = 1'b0;
    #1 check("lu1_zero_cnt", 32'(stall1), 32'd1);

    // Load-use via rt, two bubbles
    do_reset();
    idex_memread = 1'b1; idex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b1;
    #1 check("lu2_bubble1", 32'(ctl2), 32'(C_BUB));
    tick();
    idex_memread = 1'b0;
    #1 check("lu2_bubble2", 32'(ctl2), 32'(C_BUB));
    tick();
    #1 check("lu2_resume", 32'(ctl2), 32'(C_DEF));
    check("lu2_stall_cnt", 32'(stall2), 32'd2);
    idex_memread = 1'b1; id_uses_rt = 1'b0;
    #1 check("lu2_no_rt_use", 32'(ctl2), 32'(C_DEF));
    tick();
    idex_memread = 1'b0;
    tick();
    check("lu2_no_rt_cnt", 32'(stall2), 32'd2);

    // Branch in second stall cycle with three-cycle stalls
    do_reset();
    idex_memread = 1'b1; idex_rt = 5'd7; id_rs = 5'd7;
    #1 check("br_stall1", 32'(ctl3), 32'(C_BUB));
    tick();
    idex_memread = 1'b0; br_taken = 1'b1;
    #1 check("br_flush_ctl", 32'(ctl3), 32'(C_BR));
    tick();
    br_taken = 1'b0;
    #1 check("br_back_to_run", 32'(ctl3), 32'(C_DEF));
    check("br_flush_cnt", 32'(flush3), 32'd1);
    check("br_stall_cnt", 32'(stall3), 32'd1);
    br_taken = 1'b1; ext_stall = 1'b1;
    #1 check("br_over_ext", 32'(ctl3), 32'(C_BR));
    tick();
    idle();
    #1 check("br_over_ext_cnt", 32'(flush3), 32'd2);

    // Reset in the middle of a stall leaves nothing behind
    idex_memread = 1'b1; idex_rt = 5'd7; id_rs = 5'd7;
    tick();
    idex_memread = 1'b0; rst_n = 1'b0;
    #1 check("rst_mid_stall_ctl", 32'(ctl3), 32'(C_RST));
    tick();
    rst_n = 1'b1;
    #1 check("rst_mid_stall_run", 32'(ctl3), 32'(C_DEF));
    check("rst_mid_stall_cnt", 32'(stall3), 32'd0);

    // External freeze in the middle of a two-cycle load-use stall
    do_reset();
    idex_memread = 1'b1; idex_rt = 5'd9; id_rs = 5'd9;
    #1 check("ext_bubble1", 32'(ctl2), 32'(C_BUB));
    tick();
    idex_memread = 1'b0; ext_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("ext_frozen", 32'(ctl2), 32'(C_EXT));
      tick();
    end
    ext_stall = 1'b0;
    #1 check("ext_bubble2", 32'(ctl2), 32'(C_BUB));
    tick();
    #1 check("ext_resume", 32'(ctl2), 32'(C_DEF));
    check("ext_stall_cnt", 32'(stall2), 32'd6);

    // Flush counter saturation on the 4-bit instance
    do_reset();
    for (int i = 0; i < 20; i++) begin
      br_taken = 1'b1;
      tick();
      br_taken = 1'b0;
      check("sat_flush_cnt", 32'(flush2), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    tick();
    check("sat_flush_hold", 32'(flush2), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
